syscon_ctrl: RTL and testbench

Parametrised system-control register block: the next generation of the syscon register slave. It sits on the Wishbone bus beside the clock/reset generator, synchronises the PLL `locked` flag, and drives a configurable LED bank. It sequences N downstream reset domains, releasing them in index order with a programmable stretch, and re-asserts them on loss of lock. It also provides sticky lock-loss status with an interrupt, a scratch register and a free-running cycle counter.

---
 rtl/syscon_ctrl.sv | 149 ++++++++++++++
 tb/tb_syscon_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/syscon_ctrl.sv
// syscon_ctrl: Wishbone system-control slave (ID, LEDs, reset-domain sequencer, lock status/irq, scratch, cycle counter)
// Ports:
//   wb_clk, wb_rst_n        clock and asynchronous active-low reset
//   wb_cyc_i..wb_sel_i      Wishbone slave request (byte address, byte-lane selects)
//   wb_dat_o, wb_ack_o,     Wishbone response; ack for registers 0x00-0x18, err for 0x1C,
//   wb_err_o, wb_rty_o      rty never asserted
//   locked                  PLL lock, asynchronous to wb_clk
//   leds                    LED drive from the LED register
//   domain_rst_o            active-high downstream resets, released in index order
//   irq                     level interrupt: LOCK_LOST & IRQ_EN
module syscon_ctrl #(
    parameter logic [31:0] SLAVE_ADDRESS = 32'h0000_0000,
    parameter int          aw            = 32,
    parameter int          dw            = 32,
    parameter int          NUM_LEDS      = 2,
    parameter int          NUM_DOMAINS   = 4,
    parameter int          RST_STRETCH   = 16,
    parameter logic [31:0] ID_VALUE      = 32'h5359_5343
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [aw-1:0]          wb_adr_i,
    input  logic [dw-1:0]          wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic [dw-1:0]          wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    input  logic                   locked,
    output logic [NUM_LEDS-1:0]    leds,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   irq
);
    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, IDLE} state_t;
    localparam logic [15:0] STRETCH_M1 = 16'(RST_STRETCH - 1);
    state_t                 state, state_d;
    logic [15:0]            cnt, cnt_d;
    logic [2:0]             idx, idx_d;
    logic [NUM_DOMAINS-1:0] drst_d, mask, mask_d;
    logic [31:0]            scratch, scratch_d, cycle_cnt, rdata;
    logic [2:0]             off;
    logic                   hit, req, wr, start, lock_fall;
    logic                   sync1, locked_sync, locked_prev, lock_lost, irq_en;
    logic                   unused_adr;
    assign unused_adr = ^wb_adr_i[1:0];
    assign wb_rty_o   = 1'b0;
    assign hit        = wb_adr_i[aw-1:5] == SLAVE_ADDRESS[aw-1:5];
    assign off        = wb_adr_i[4:2];
    // Gating on the registered terminations makes a held strobe terminate every other cycle.
    assign req        = wb_cyc_i & wb_stb_i & hit & ~wb_ack_o & ~wb_err_o;
    assign wr         = req & wb_we_i & (off != 3'd7);
    assign start      = wr & (off == 3'd2) & wb_sel_i[0] & wb_dat_i[0];
    assign lock_fall  = locked_prev & ~locked_sync;
    // MASK is forwarded so a write carrying both MASK and START uses the new mask.
    assign mask_d     = (wr && off == 3'd2 && wb_sel_i[1]) ? wb_dat_i[8 +: NUM_DOMAINS] : mask;
    always_comb begin
        scratch_d = scratch;
        for (int b = 0; b < 4; b++)
            if (wr && off == 3'd5 && wb_sel_i[b]) scratch_d[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
    always_comb begin
        case (off)
            3'd0:    rdata = ID_VALUE;
            3'd1:    rdata = 32'(leds);
            3'd2:    rdata = 32'({mask, 8'h00});
            3'd3:    rdata = {29'd0, state != IDLE, lock_lost, locked_sync};
            3'd4:    rdata = {31'd0, irq_en};
            3'd5:    rdata = scratch;
            3'd6:    rdata = cycle_cnt;
            default: rdata = '0;
        endcase
    end
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        drst_d  = domain_rst_o;
        if (lock_fall) begin
            state_d = WAIT_LOCK;
            drst_d  = '1;
        end else begin
            case (state)
                WAIT_LOCK: if (locked_sync) begin
                    state_d = HOLD;
                    cnt_d   = STRETCH_M1;
                    idx_d   = 3'd0;
                end
                HOLD, RELEASE: if (cnt == 16'd0) begin
                    for (int d = 0; d < NUM_DOMAINS; d++)
                        if (idx == 3'(d)) drst_d[d] = 1'b0;
                    idx_d   = idx + 3'd1;
                    cnt_d   = STRETCH_M1;
                    state_d = (idx == 3'(NUM_DOMAINS - 1)) ? IDLE : RELEASE;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
                default: if (start) begin
                    drst_d  = domain_rst_o | mask_d;
                    state_d = HOLD;
                    cnt_d   = STRETCH_M1;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            idx          <= '0;
            domain_rst_o <= '1;
            sync1        <= 1'b0;
            locked_sync  <= 1'b0;
            locked_prev  <= 1'b0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            leds         <= '0;
            mask         <= '1;
            scratch      <= '0;
            irq_en       <= 1'b0;
            lock_lost    <= 1'b0;
            irq          <= 1'b0;
            cycle_cnt    <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            domain_rst_o <= drst_d;
            sync1        <= locked;
            locked_sync  <= sync1;
            locked_prev  <= locked_sync;
            wb_ack_o     <= req & (off != 3'd7);
            wb_err_o     <= req & (off == 3'd7);
            wb_dat_o     <= (req & ~wb_we_i) ? rdata : '0;
            if (wr && off == 3'd1 && wb_sel_i[0]) leds <= wb_dat_i[NUM_LEDS-1:0];
            mask         <= mask_d;
            scratch      <= scratch_d;
            if (wr && off == 3'd4 && wb_sel_i[0]) irq_en <= wb_dat_i[0];
            // A lock loss in the same cycle as a W1C clear keeps the flag set.
            lock_lost    <= lock_fall | (lock_lost & ~(wr && off == 3'd3 && wb_sel_i[0] && wb_dat_i[1]));
            irq          <= lock_lost & irq_en;
            cycle_cnt    <= cycle_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_syscon_ctrl.sv
// tb_syscon_ctrl: directed, table-driven bench for syscon_ctrl at default parameters
module tb_syscon_ctrl;
    logic        wb_clk = 1'b0, wb_rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic        locked = 1'b1;
    logic [1:0]  leds;
    logic [3:0]  domain_rst_o;
    logic        irq;
    int          checks = 0, errors = 0, edge_cnt = 0;

    syscon_ctrl dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .locked(locked), .leds(leds), .domain_rst_o(domain_rst_o), .irq(irq)
    );

    always #5 wb_clk = ~wb_clk;
    always @(posedge wb_clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_dat;
        logic        exp_ack;
        logic        exp_err;
        logic [1:0]  exp_leds;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge, returns at the negedge one cycle after the termination cycle.
    task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output logic ack,
                       output logic err);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        @(posedge wb_clk);
        @(negedge wb_clk);
        rd = wb_dat_o; ack = wb_ack_o; err = wb_err_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ack, err;
        bus(adr, 1'b0, '0, 4'hF, rd, ack, err);
        check({name, " ack"}, 32'(ack), 32'd1);
        check({name, " data"}, rd, exp);
    endtask

    task automatic wr_chk(input string name, input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        logic        ack, err;
        bus(adr, 1'b1, dat, 4'hF, rd, ack, err);
        check({name, " ack"}, 32'(ack), 32'd1);
    endtask

    // Single write whose request edge is reported, so timing can be measured from it.
    task automatic wr_mark(input logic [31:0] adr, input logic [31:0] dat, output int w);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = 4'hF;
        @(posedge wb_clk);
        @(negedge wb_clk);
        w = edge_cnt;
        check("mark write ack", 32'(wb_ack_o), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    initial begin
        int          r0, w, l, k;
        logic [31:0] rd, c1, c2;
        logic        ack, err;
        logic [3:0]  exp_rst;

        vecs.push_back('{32'h00, 1'b0, 32'h0,         4'hF, 32'h5359_5343, 1'b1, 1'b0, 2'b00});
        vecs.push_back('{32'h14, 1'b1, 32'hA5A5_A5A5, 4'h2, 32'h0,         1'b1, 1'b0, 2'b00});
        vecs.push_back('{32'h14, 1'b0, 32'h0,         4'hF, 32'h0000_A500, 1'b1, 1'b0, 2'b00});
        vecs.push_back('{32'h04, 1'b1, 32'h3,         4'hF, 32'h0,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h04, 1'b0, 32'h0,         4'hF, 32'h3,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h04, 1'b1, 32'hFFFF_FFFC, 4'h1, 32'h0,         1'b1, 1'b0, 2'b00});
        vecs.push_back('{32'h04, 1'b0, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0, 2'b00});
        vecs.push_back('{32'h04, 1'b1, 32'h3,         4'hE, 32'h0,         1'b1, 1'b0, 2'b00});
        vecs.push_back('{32'h04, 1'b1, 32'hFFFF_FFFF, 4'h1, 32'h0,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h04, 1'b0, 32'h0,         4'hF, 32'h3,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h1C, 1'b0, 32'h0,         4'hF, 32'h0,         1'b0, 1'b1, 2'b11});
        vecs.push_back('{32'h1C, 1'b1, 32'h5,         4'hF, 32'h0,         1'b0, 1'b1, 2'b11});
        vecs.push_back('{32'h08, 1'b0, 32'h0,         4'hF, 32'h0000_0F00, 1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h0C, 1'b0, 32'h0,         4'hF, 32'h1,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h10, 1'b0, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h00, 1'b1, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h00, 1'b0, 32'h0,         4'hF, 32'h5359_5343, 1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h20, 1'b0, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0, 2'b11});
        vecs.push_back('{32'h14, 1'b1, 32'hFFFF_FFFF, 4'h9, 32'h0,         1'b1, 1'b0, 2'b11});
        vecs.push_back('{32'h14, 1'b0, 32'h0,         4'hF, 32'hFF00_A5FF, 1'b1, 1'b0, 2'b11});

        // Reset values while held in reset
        repeat (3) @(negedge wb_clk);
        check("rst dat", wb_dat_o, 32'h0);
        check("rst ack", 32'(wb_ack_o), 32'd0);
        check("rst err", 32'(wb_err_o), 32'd0);
        check("rst rty", 32'(wb_rty_o), 32'd0);
        check("rst leds", 32'(leds), 32'd0);
        check("rst domains", 32'(domain_rst_o), 32'hF);
        check("rst irq", 32'(irq), 32'd0);

        // Power-up sequence with locked held high
        wb_rst_n = 1'b1;
        r0 = edge_cnt;
        while (edge_cnt < r0 + 70) begin
            @(negedge wb_clk);
            k = edge_cnt - r0;
            exp_rst = k >= 67 ? 4'h0 : k >= 51 ? 4'h8 : k >= 35 ? 4'hC : k >= 19 ? 4'hE : 4'hF;
            check($sformatf("powerup edge %0d domains", k), 32'(domain_rst_o), 32'(exp_rst));
        end
        rd_chk("status idle", 32'h0C, 32'h1);

        // Register map vectors
        foreach (vecs[i]) begin
            bus(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, rd, ack, err);
            check($sformatf("vec%0d dat", i), rd, vecs[i].exp_dat);
            check($sformatf("vec%0d ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
        end

        // Held strobe: terminations every other cycle
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0; wb_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            check($sformatf("held stb ack %0d", i), 32'(wb_ack_o), 32'(i % 2 == 0));
            check($sformatf("held stb dat %0d", i), wb_dat_o, (i % 2 == 0) ? 32'h5359_5343 : 32'h0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge wb_clk);

        // Cycle counter: value at the request edge, edges counted from reset release
        bus(32'h18, 1'b0, '0, 4'hF, c1, ack, err);
        check("cycle abs", c1, 32'(edge_cnt - r0 - 2));
        bus(32'h18, 1'b0, '0, 4'hF, c2, ack, err);
        check("cycle diff", c2 - c1, 32'd2);

        // Soft reset of domains 1 and 3
        wr_mark(32'h08, 32'h0000_0A01, w);
        check("soft start domains", 32'(domain_rst_o), 32'hA);
        @(negedge wb_clk);
        rd_chk("status busy", 32'h0C, 32'h5);
        while (edge_cnt < w + 66) begin
            @(negedge wb_clk);
            k = edge_cnt - w;
            exp_rst = k >= 64 ? 4'h0 : k >= 32 ? 4'h8 : 4'hA;
            check($sformatf("soft edge %0d domains", k), 32'(domain_rst_o), 32'(exp_rst));
        end
        rd_chk("mask readback", 32'h08, 32'h0000_0A00);

        // Lock loss during RELEASE
        wr_chk("irq_en write", 32'h10, 32'h1);
        wr_chk("mask all", 32'h08, 32'h0000_0F00);
        wr_mark(32'h08, 32'h0000_0F01, w);
        while (edge_cnt < w + 17) @(negedge wb_clk);
        check("loss pre domains", 32'(domain_rst_o), 32'hE);
        locked = 1'b0;
        @(negedge wb_clk);
        @(negedge wb_clk);
        check("loss edge2 domains", 32'(domain_rst_o), 32'hE);
        @(negedge wb_clk);
        check("loss edge3 domains", 32'(domain_rst_o), 32'hF);
        @(negedge wb_clk);
        check("loss irq", 32'(irq), 32'd1);
        rd_chk("status lost", 32'h0C, 32'h6);
        locked = 1'b1;
        l = edge_cnt;
        while (edge_cnt < l + 18) @(negedge wb_clk);
        check("relock edge18 domains", 32'(domain_rst_o), 32'hF);
        @(negedge wb_clk);
        check("relock edge19 domains", 32'(domain_rst_o), 32'hE);
        while (edge_cnt < l + 67) @(negedge wb_clk);
        check("relock edge67 domains", 32'(domain_rst_o), 32'h0);
        rd_chk("status relocked", 32'h0C, 32'h3);
        check("irq held", 32'(irq), 32'd1);
        wr_chk("status clear", 32'h0C, 32'h2);
        check("irq cleared", 32'(irq), 32'd0);
        rd_chk("status cleared", 32'h0C, 32'h1);

        // Asynchronous reset during an ack cycle
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0; wb_sel_i = 4'hF;
        @(posedge wb_clk);
        @(negedge wb_clk);
        check("midxfer ack before", 32'(wb_ack_o), 32'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        check("midxfer ack", 32'(wb_ack_o), 32'd0);
        check("midxfer dat", wb_dat_o, 32'h0);
        check("midxfer err", 32'(wb_err_o), 32'd0);
        check("midxfer leds", 32'(leds), 32'd0);
        check("midxfer domains", 32'(domain_rst_o), 32'hF);
        check("midxfer irq", 32'(irq), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
